// File: rtl/crc4_frame_checker_if.sv
// Serial-line and result bundle between the crc4 frame checker and its surroundings.
// Latency: none (wires only). Backpressure: none; the serial line cannot be stalled.
// master drives the serial line and crc4 remainder, slave is the checker itself.
interface crc4_frame_checker_if #(
    parameter int DATA_BITS = 8
);
    logic                 serialClk;
    logic                 serialData;
    logic                 frameSync;
    logic [3:0]           crc4In;
    logic                 crcReset;
    logic                 crcEnable;
    logic [DATA_BITS-1:0] rxData;
    logic                 frameValid;
    logic                 crcError;
    logic                 busy;
    logic [7:0]           crcErrCnt;

    modport master (
        output serialClk, serialData, frameSync, crc4In,
        input  crcReset, crcEnable, rxData, frameValid, crcError, busy, crcErrCnt
    );

    modport slave (
        input  serialClk, serialData, frameSync, crc4In,
        output crcReset, crcEnable, rxData, frameValid, crcError, busy, crcErrCnt
    );
endinterface

// File: rtl/crc4_frame_checker.sv
// Deserializes a DATA_BITS payload, sequences a companion crc4 and checks its 4 trailing CRC bits.
// Latency: rxData and frameValid/crcError strobe 1 cycle after the 4th CRC-bit serialClk rise.
// Backpressure: none; a new frameSync rise aborts any frame in progress. CRC_ERR_CNT_EN adds crcErrCnt.
module crc4_frame_checker #(
    parameter int DATA_BITS = 8
) (
    input  logic                   masterClk,
    input  logic                   reset,
    crc4_frame_checker_if.slave    bus
);
    // Counter must also reach 3 in the CRC phase, even for very short payloads.
    localparam int CNT_W = ($clog2(DATA_BITS + 1) > 3) ? $clog2(DATA_BITS + 1) : 3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        DATA = 3'd2,
        CRC  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t               state;
    logic                 prevSerialClk;
    logic                 prevFrameSync;
    logic [CNT_W-1:0]     bitCnt;
    logic                 mismatch;
    logic [DATA_BITS-1:0] shiftReg;
    logic [DATA_BITS-1:0] rxDataReg;
    logic                 crcResetReg;
    logic                 crcEnableReg;
    logic                 frameValidReg;
    logic                 crcErrorReg;

    logic sclkRise;
    logic syncRise;
    logic frameBad;
    logic unusedCrcBits;

    assign sclkRise      = bus.serialClk & ~prevSerialClk;
    assign syncRise      = bus.frameSync & ~prevFrameSync;
    // crc4In[3] is sampled before crc4 shifts on this same edge.
    assign frameBad      = mismatch | (bus.serialData ^ bus.crc4In[3]);
    assign unusedCrcBits = ^bus.crc4In[2:0];

    always_ff @(posedge masterClk) begin
        if (!reset) begin
            state         <= IDLE;
            prevSerialClk <= 1'b1;
            prevFrameSync <= 1'b1;
            bitCnt        <= '0;
            mismatch      <= 1'b0;
            shiftReg      <= '0;
            rxDataReg     <= '0;
            crcResetReg   <= 1'b0;
            crcEnableReg  <= 1'b0;
            frameValidReg <= 1'b0;
            crcErrorReg   <= 1'b0;
        end else begin
            prevSerialClk <= bus.serialClk;
            prevFrameSync <= bus.frameSync;
            crcResetReg   <= 1'b0;
            frameValidReg <= 1'b0;
            crcErrorReg   <= 1'b0;

            if (syncRise) begin
                state        <= CLR;
                crcResetReg  <= 1'b1;
                crcEnableReg <= 1'b1;
                bitCnt       <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        crcEnableReg <= 1'b0;
                    end
                    CLR: begin
                        state <= DATA;
                    end
                    DATA: begin
                        if (sclkRise) begin
                            shiftReg <= (shiftReg << 1) | DATA_BITS'(bus.serialData);
                            if (bitCnt == CNT_W'(DATA_BITS - 1)) begin
                                state        <= CRC;
                                bitCnt       <= '0;
                                mismatch     <= 1'b0;
                                crcEnableReg <= 1'b0;
                            end else begin
                                bitCnt <= bitCnt + 1'b1;
                            end
                        end
                    end
                    CRC: begin
                        if (sclkRise) begin
                            mismatch <= frameBad;
                            if (bitCnt == CNT_W'(3)) begin
                                state         <= DONE;
                                rxDataReg     <= shiftReg;
                                frameValidReg <= ~frameBad;
                                crcErrorReg   <= frameBad;
                            end else begin
                                bitCnt <= bitCnt + 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state        <= IDLE;
                        crcEnableReg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.crcReset   = crcResetReg;
    assign bus.crcEnable  = crcEnableReg;
    assign bus.rxData     = rxDataReg;
    assign bus.frameValid = frameValidReg;
    assign bus.crcError   = crcErrorReg;
    assign bus.busy       = (state != IDLE);

`ifdef CRC_ERR_CNT_EN
    logic [7:0] errCnt;

    always_ff @(posedge masterClk) begin
        if (!reset) begin
            errCnt <= 8'h00;
        end else if (crcErrorReg && (errCnt != 8'hFF)) begin
            errCnt <= errCnt + 8'h01;
        end
    end

    assign bus.crcErrCnt = errCnt;
`else
    assign bus.crcErrCnt = 8'h00;
`endif
endmodule

// File: tb/tb_crc4_frame_checker.sv
// Bench for crc4_frame_checker with a behavioural crc4 companion and polynomial-division reference.
module tb_crc4_frame_checker;
    logic masterClk = 1'b0;
    logic reset     = 1'b0;
    always #5 masterClk = ~masterClk;

    crc4_frame_checker_if #(.DATA_BITS(8)) bus ();
    crc4_frame_checker #(.DATA_BITS(8)) dut (
        .masterClk (masterClk),
        .reset     (reset),
        .bus       (bus)
    );

    // Companion crc4: message*x^4 mod x^4+x+1 while enabled, shifts remainder out of bit 3 otherwise.
    logic [3:0] crcModel   = 4'h0;
    logic       tbPrevSclk = 1'b0;
    always @(posedge masterClk) begin
        tbPrevSclk <= bus.serialClk;
        if (bus.crcReset)
            crcModel <= 4'h0;
        else if (bus.serialClk && !tbPrevSclk) begin
            if (bus.crcEnable)
                crcModel <= {crcModel[2:0], 1'b0} ^ ((crcModel[3] ^ bus.serialData) ? 4'h3 : 4'h0);
            else
                crcModel <= {crcModel[2:0], 1'b0};
        end
    end
    assign bus.crc4In = crcModel;

    int checks = 0;
    int errors = 0;
    int nValid = 0, nErr = 0, nRst = 0, nViol = 0;
    logic lastV = 1'b0, lastE = 1'b0;
    int expErrCnt = 0;
    int phaseMax = 4;

    always @(negedge masterClk) begin
        if (bus.frameValid) nValid++;
        if (bus.crcError)   nErr++;
        if (bus.crcReset)   nRst++;
        if ((bus.frameValid && bus.crcError) || (bus.frameValid && lastV) || (bus.crcError && lastE))
            nViol++;
        lastV = bus.frameValid;
        lastE = bus.crcError;
    end

    // Reference remainder by long division of data*x^4 by 10011.
    function automatic logic [3:0] crc_ref(input logic [7:0] d);
        logic [11:0] m;
        m = {d, 4'b0000};
        for (int i = 11; i >= 4; i--)
            if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
        return m[3:0];
    endfunction

    function automatic int expected_cnt();
`ifdef CRC_ERR_CNT_EN
        return expErrCnt;
`else
        return 0;
`endif
    endfunction

    task automatic send_bit(input logic b);
        int lo, hi;
        lo = $urandom_range(2, phaseMax);
        hi = $urandom_range(2, phaseMax);
        bus.serialClk  = 1'b0;
        bus.serialData = b;
        repeat (lo) @(negedge masterClk);
        bus.serialClk = 1'b1;
        repeat (hi) @(negedge masterClk);
    endtask

    task automatic start_frame();
        bus.frameSync = 1'b1;
        repeat (3) @(negedge masterClk);
        bus.frameSync = 1'b0;
    endtask

    task automatic send_data(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
    endtask

    task automatic send_crc(input logic [3:0] c);
        for (int i = 3; i >= 0; i--) send_bit(c[i]);
    endtask

    task automatic finish_frame();
        bus.serialClk = 1'b0;
        repeat (3) @(negedge masterClk);
    endtask

    task automatic note_bad();
        if (expErrCnt < 255) expErrCnt++;
    endtask

    task automatic test_reset();
        bus.serialClk = 1'b0; bus.serialData = 1'b0; bus.frameSync = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge masterClk);
        checks++; if (bus.rxData !== 8'h00) begin errors++; $display("FAIL reset_rxData: got %0h expected 0", bus.rxData); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.crcEnable !== 1'b0) begin errors++; $display("FAIL reset_crcEnable: got %b expected 0", bus.crcEnable); end
        checks++; if (bus.crcReset !== 1'b0) begin errors++; $display("FAIL reset_crcReset: got %b expected 0", bus.crcReset); end
        checks++; if ({bus.frameValid, bus.crcError} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b expected 00", {bus.frameValid, bus.crcError}); end
        checks++; if (bus.crcErrCnt !== 8'h00) begin errors++; $display("FAIL reset_crcErrCnt: got %0d expected 0", bus.crcErrCnt); end
        reset = 1'b1;
        repeat (2) @(negedge masterClk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_good_frame();
        int v0, e0;
        v0 = nValid; e0 = nErr;
        start_frame();
        send_bit(1'b1);
        checks++; if (bus.crcEnable !== 1'b1) begin errors++; $display("FAIL good_enable_data: got %b expected 1", bus.crcEnable); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL good_busy: got %b expected 1", bus.busy); end
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        checks++; if (bus.crc4In !== crc_ref(8'h80)) begin errors++; $display("FAIL good_crc4In: got %0h expected %0h", bus.crc4In, crc_ref(8'h80)); end
        checks++; if (bus.crcEnable !== 1'b0) begin errors++; $display("FAIL good_enable_crc: got %b expected 0", bus.crcEnable); end
        send_crc(4'b1110);
        finish_frame();
        checks++; if (bus.rxData !== 8'h80) begin errors++; $display("FAIL good_rxData: got %0h expected 80", bus.rxData); end
        checks++; if (nValid - v0 !== 1) begin errors++; $display("FAIL good_valid_count: got %0d expected 1", nValid - v0); end
        checks++; if (nErr - e0 !== 0) begin errors++; $display("FAIL good_error_count: got %0d expected 0", nErr - e0); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL good_idle: got %b expected 0", bus.busy); end
    endtask

    task automatic test_zero_frame();
        int v0, e0;
        v0 = nValid; e0 = nErr;
        start_frame(); send_data(8'h00); send_crc(4'b0000); finish_frame();
        checks++; if (bus.rxData !== 8'h00) begin errors++; $display("FAIL zero_rxData: got %0h expected 0", bus.rxData); end
        checks++; if (nValid - v0 !== 1 || nErr - e0 !== 0) begin errors++; $display("FAIL zero_strobes: got valid %0d err %0d expected 1 0", nValid - v0, nErr - e0); end
    endtask

    task automatic test_bad_crc();
        int v0, e0;
        v0 = nValid; e0 = nErr;
        start_frame(); send_data(8'h80); send_crc(4'b1111); finish_frame();
        note_bad();
        checks++; if (nErr - e0 !== 1 || nValid - v0 !== 0) begin errors++; $display("FAIL bad_strobes: got err %0d valid %0d expected 1 0", nErr - e0, nValid - v0); end
        checks++; if (bus.rxData !== 8'h80) begin errors++; $display("FAIL bad_rxData: got %0h expected 80", bus.rxData); end
        checks++; if (int'(bus.crcErrCnt) !== expected_cnt()) begin errors++; $display("FAIL bad_crcErrCnt: got %0d expected %0d", bus.crcErrCnt, expected_cnt()); end
    endtask

    task automatic test_random_frames();
        logic [7:0] d;
        logic [3:0] c;
        bit corrupt;
        int v0, e0;
        for (int n = 0; n < 24; n++) begin
            d = 8'($urandom);
            corrupt = 1'($urandom_range(0, 1));
            c = crc_ref(d);
            if (corrupt) c = c ^ 4'($urandom_range(1, 15));
            v0 = nValid; e0 = nErr;
            start_frame(); send_data(d); send_crc(c); finish_frame();
            if (corrupt) note_bad();
            checks++; if (bus.rxData !== d) begin errors++; $display("FAIL rand_rxData[%0d]: got %0h expected %0h", n, bus.rxData, d); end
            checks++; if (nValid - v0 !== (corrupt ? 0 : 1) || nErr - e0 !== (corrupt ? 1 : 0)) begin
                errors++; $display("FAIL rand_strobes[%0d]: got valid %0d err %0d expected corrupt=%0d", n, nValid - v0, nErr - e0, corrupt);
            end
        end
        checks++; if (int'(bus.crcErrCnt) !== expected_cnt()) begin errors++; $display("FAIL rand_crcErrCnt: got %0d expected %0d", bus.crcErrCnt, expected_cnt()); end
    endtask

    task automatic test_abort();
        logic [7:0] prevRx;
        int v0, e0, r0;
        prevRx = bus.rxData;
        v0 = nValid; e0 = nErr; r0 = nRst;
        start_frame();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        start_frame();
        checks++; if (bus.rxData !== prevRx) begin errors++; $display("FAIL abort_rxData_kept: got %0h expected %0h", bus.rxData, prevRx); end
        checks++; if (nValid - v0 !== 0 || nErr - e0 !== 0) begin errors++; $display("FAIL abort_no_strobe: got valid %0d err %0d expected 0 0", nValid - v0, nErr - e0); end
        send_data(8'h00); send_crc(4'b0000); finish_frame();
        checks++; if (nValid - v0 !== 1) begin errors++; $display("FAIL abort_valid_count: got %0d expected 1", nValid - v0); end
        checks++; if (nRst - r0 !== 2) begin errors++; $display("FAIL abort_crcReset_count: got %0d expected 2", nRst - r0); end
        checks++; if (bus.rxData !== 8'h00) begin errors++; $display("FAIL abort_rxData: got %0h expected 0", bus.rxData); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] dA, dB;
        logic [3:0] cA;
        int v0, r0;
        dA = 8'($urandom); dB = 8'($urandom);
        cA = crc_ref(dA);
        v0 = nValid; r0 = nRst;
        start_frame(); send_data(dA);
        for (int i = 3; i >= 1; i--) send_bit(cA[i]);
        bus.serialClk = 1'b0; bus.serialData = cA[0];
        repeat (2) @(negedge masterClk);
        bus.serialClk = 1'b1;
        @(negedge masterClk);
        start_frame();
        checks++; if (bus.rxData !== dA) begin errors++; $display("FAIL b2b_first_rxData: got %0h expected %0h", bus.rxData, dA); end
        checks++; if (nValid - v0 !== 1) begin errors++; $display("FAIL b2b_first_valid: got %0d expected 1", nValid - v0); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_restart_busy: got %b expected 1", bus.busy); end
        send_data(dB); send_crc(crc_ref(dB)); finish_frame();
        checks++; if (bus.rxData !== dB) begin errors++; $display("FAIL b2b_second_rxData: got %0h expected %0h", bus.rxData, dB); end
        checks++; if (nValid - v0 !== 2 || nRst - r0 !== 2) begin errors++; $display("FAIL b2b_counts: got valid %0d crcReset %0d expected 2 2", nValid - v0, nRst - r0); end
    endtask

    task automatic test_reset_mid_crc();
        logic [3:0] c;
        int v0, e0;
        c = crc_ref(8'hA5);
        v0 = nValid; e0 = nErr;
        start_frame(); send_data(8'hA5); send_bit(c[3]);
        bus.serialClk = 1'b0; bus.serialData = c[2];
        @(negedge masterClk);
        reset = 1'b0;
        @(negedge masterClk);
        reset = 1'b1;
        expErrCnt = 0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.rxData !== 8'h00) begin errors++; $display("FAIL midrst_rxData: got %0h expected 0", bus.rxData); end
        checks++; if (bus.crcEnable !== 1'b0) begin errors++; $display("FAIL midrst_crcEnable: got %b expected 0", bus.crcEnable); end
        @(negedge masterClk);
        bus.serialClk = 1'b1;
        repeat (2) @(negedge masterClk);
        send_bit(c[1]); send_bit(c[0]);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom));
        finish_frame();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_ignored_edges: got busy %b expected 0", bus.busy); end
        checks++; if (nValid - v0 !== 0 || nErr - e0 !== 0) begin errors++; $display("FAIL midrst_no_strobe: got valid %0d err %0d expected 0 0", nValid - v0, nErr - e0); end
        checks++; if (bus.rxData !== 8'h00 || bus.crcErrCnt !== 8'h00) begin errors++; $display("FAIL midrst_state: got rx %0h cnt %0d expected 0 0", bus.rxData, bus.crcErrCnt); end
    endtask

`ifdef CRC_ERR_CNT_EN
    task automatic test_saturation();
        int e0;
        e0 = nErr;
        phaseMax = 2;
        for (int n = 0; n < 260; n++) begin
            start_frame(); send_data(8'h80); send_crc(4'b1111); finish_frame();
            note_bad();
        end
        phaseMax = 4;
        checks++; if (nErr - e0 !== 260) begin errors++; $display("FAIL sat_error_strobes: got %0d expected 260", nErr - e0); end
        checks++; if (int'(bus.crcErrCnt) !== expErrCnt || bus.crcErrCnt !== 8'hFF) begin errors++; $display("FAIL sat_crcErrCnt: got %0d expected 255", bus.crcErrCnt); end
    endtask
`endif

    task automatic test_strobe_rules();
        checks++; if (nViol !== 0) begin errors++; $display("FAIL strobe_rules: got %0d violations expected 0", nViol); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_zero_frame();
        test_bad_crc();
        test_random_frames();
        test_abort();
        test_back_to_back();
        test_reset_mid_crc();
`ifdef CRC_ERR_CNT_EN
        test_saturation();
`endif
        test_strobe_rules();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
